mem_stage: RTL and testbench

- Memory-access stage directly downstream of the execution stage. Consumes the ALU result as the effective address and the rs2 operand as store data.
- Performs byte, half and word loads and stores over a valid/ready data-memory request channel with a separate read-response channel, then sign- or zero-extends load data.
- Registers the write-back payload and holds the upstream pipeline while an access is outstanding.
- Flags misaligned accesses and memory timeouts.

---
 rtl/mem_stage_if.sv | 22 ++
 rtl/mem_stage.sv | 204 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Data-memory channel between the memory-access stage and the data memory:
// a valid/ready request path plus a separate read-response path.
interface mem_stage_if;
  logic        MemReq;
  logic        MemReady;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWdata;
  logic [3:0]  MemBe;
  logic        MemRvalid;
  logic [31:0] MemRdata;

  modport master (
    output MemReq, MemWe, MemAddr, MemWdata, MemBe,
    input  MemReady, MemRvalid, MemRdata
  );

  modport slave (
    input  MemReq, MemWe, MemAddr, MemWdata, MemBe,
    output MemReady, MemRvalid, MemRdata
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: byte/half/word loads and stores with lane steering,
// load extension, misalignment detection, timeout abort and a registered write-back.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        InValid,
  input  logic [31:0] ALU_result,
  input  logic [31:0] Rs2Data,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [4:0]  RdIn,
  input  logic        RegWriteIn,
  output logic        Stall,
  mem_stage_if.master mem,
  output logic        WbValid,
  output logic [4:0]  WbRd,
  output logic        WbRegWrite,
  output logic [31:0] WbData,
  output logic        Misalign,
  output logic        BusErr
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  localparam logic [31:0] TLIM = 32'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [31:0] addr_q, wdata_q, cnt;
  logic [3:0]  be_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic        we_q, rw_q;

  logic        is_mem, is_half, is_word, misaligned, latch, timeout;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, ldata;
  logic [7:0]  lbyte;
  logic [15:0] lhalf;

  logic        wb_valid_d, wb_rw_d, mis_d, berr_d;
  logic [4:0]  wb_rd_d;
  logic [31:0] wb_data_d;

  // Funct3[1] set means word-sized; reserved codes therefore behave as LW.
  always_comb begin
    is_mem     = MemRead | MemWrite;
    is_half    = (Funct3[1:0] == 2'b01);
    is_word    = Funct3[1];
    misaligned = (is_half & ALU_result[0]) | (is_word & (ALU_result[1:0] != 2'b00));
    if (is_word) begin
      be_d    = 4'b1111;
      wdata_d = Rs2Data;
    end else if (is_half) begin
      be_d    = 4'b0011 << ALU_result[1:0];
      wdata_d = {2{Rs2Data[15:0]}};
    end else begin
      be_d    = 4'b0001 << ALU_result[1:0];
      wdata_d = {4{Rs2Data[7:0]}};
    end
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    lbyte = mem.MemRdata[7:0];
      2'd1:    lbyte = mem.MemRdata[15:8];
      2'd2:    lbyte = mem.MemRdata[23:16];
      default: lbyte = mem.MemRdata[31:24];
    endcase
    lhalf = addr_q[1] ? mem.MemRdata[31:16] : mem.MemRdata[15:0];
    if (f3_q[1])
      ldata = mem.MemRdata;
    else if (f3_q[0])
      ldata = {{16{lhalf[15] & ~f3_q[2]}}, lhalf};
    else
      ldata = {{24{lbyte[7] & ~f3_q[2]}}, lbyte};
  end

  assign timeout = (cnt >= TLIM);

  assign mem.MemReq   = (state == REQ);
  assign mem.MemWe    = we_q;
  assign mem.MemAddr  = {addr_q[31:2], 2'b00};
  assign mem.MemWdata = wdata_q;
  assign mem.MemBe    = be_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Stall is released in whichever cycle registers a result, so upstream can advance
  // on the same edge that returns the FSM to IDLE.
  always_comb begin
    state_nxt  = state;
    Stall      = 1'b0;
    latch      = 1'b0;
    wb_valid_d = 1'b0;
    wb_rw_d    = 1'b0;
    wb_rd_d    = WbRd;
    wb_data_d  = WbData;
    mis_d      = 1'b0;
    berr_d     = 1'b0;
    unique case (state)
      IDLE: begin
        if (InValid) begin
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_rw_d    = RegWriteIn;
            wb_rd_d    = RdIn;
            wb_data_d  = ALU_result;
          end else if (misaligned) begin
            wb_valid_d = 1'b1;
            mis_d      = 1'b1;
            wb_rd_d    = RdIn;
          end else begin
            Stall     = 1'b1;
            latch     = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        if (mem.MemReady) begin
          if (we_q) begin
            state_nxt  = IDLE;
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
          end else begin
            state_nxt = WAIT;
            Stall     = 1'b1;
          end
        end else if (timeout) begin
          state_nxt  = IDLE;
          wb_valid_d = 1'b1;
          berr_d     = 1'b1;
        end else begin
          Stall = 1'b1;
        end
      end
      WAIT: begin
        if (mem.MemRvalid) begin
          state_nxt  = IDLE;
          wb_valid_d = 1'b1;
          wb_rw_d    = rw_q;
          wb_rd_d    = rd_q;
          wb_data_d  = ldata;
        end else if (timeout) begin
          state_nxt  = IDLE;
          wb_valid_d = 1'b1;
          berr_d     = 1'b1;
        end else begin
          Stall = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      cnt     <= '0;
    end else if (latch) begin
      addr_q  <= ALU_result;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= MemWrite;
      f3_q    <= Funct3;
      rd_q    <= RdIn;
      rw_q    <= RegWriteIn;
      cnt     <= '0;
    end else if (state != IDLE) begin
      cnt <= cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WbValid    <= 1'b0;
      WbRd       <= '0;
      WbRegWrite <= 1'b0;
      WbData     <= '0;
      Misalign   <= 1'b0;
      BusErr     <= 1'b0;
    end else begin
      WbValid    <= wb_valid_d;
      WbRd       <= wb_rd_d;
      WbRegWrite <= wb_rw_d;
      WbData     <= wb_data_d;
      Misalign   <= mis_d;
      BusErr     <= berr_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: an access-level reference model predicts every
// write-back event and request beat; a negedge compare process checks them each cycle.
module tb_mem_stage;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        InValid, MemRead, MemWrite, RegWriteIn;
  logic [31:0] ALU_result, Rs2Data;
  logic [2:0]  Funct3;
  logic [4:0]  RdIn;
  logic        Stall, WbValid, WbRegWrite, Misalign, BusErr;
  logic [4:0]  WbRd;
  logic [31:0] WbData;

  mem_stage_if mif ();

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .InValid    (InValid),
    .ALU_result (ALU_result),
    .Rs2Data    (Rs2Data),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Funct3     (Funct3),
    .RdIn       (RdIn),
    .RegWriteIn (RegWriteIn),
    .Stall      (Stall),
    .mem        (mif),
    .WbValid    (WbValid),
    .WbRd       (WbRd),
    .WbRegWrite (WbRegWrite),
    .WbData     (WbData),
    .Misalign   (Misalign),
    .BusErr     (BusErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        chkData;
    logic        mis;
    logic        berr;
  } ev_t;

  ev_t         evq[$];
  int          errors = 0;
  int          checks = 0;
  logic        checkOn = 1'b0;
  logic        expStall = 1'b0, expReq = 1'b0, expWe = 1'b0;
  logic [31:0] expAddr = '0, expWdata = '0;
  logic [3:0]  expBe = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int sizeBytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] modelBe(input logic [2:0] f3, input logic [31:0] addr);
    int n = sizeBytes(f3);
    int off = int'(addr % 4);
    logic [3:0] be = '0;
    for (int b = 0; b < 4; b++) be[b] = (b >= off) && (b < off + n);
    return be;
  endfunction

  function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] rs2);
    int n = sizeBytes(f3);
    logic [31:0] w = '0;
    for (int b = 0; b < 4; b++) w = w | (((rs2 >> (8 * (b % n))) & 32'hFF) << (8 * b));
    return w;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] rdata);
    int n = sizeBytes(f3);
    logic [31:0] v, mask;
    if (n == 4) return rdata;
    mask = (32'h1 << (8 * n)) - 32'h1;
    v = (rdata >> (8 * int'(addr % 4))) & mask;
    if (!f3[2] && v[8 * n - 1]) v = v | ~mask;
    return v;
  endfunction

  // Every cycle: the combinational handshake, the request beat, and the write-back event.
  always @(negedge clk) begin : cmp
    ev_t ev;
    if (checkOn) begin
      if (!rst_n) begin
        checkOutput("rst_memreq", 32'(mif.MemReq), 32'd0);
        checkOutput("rst_wbvalid", 32'(WbValid), 32'd0);
        checkOutput("rst_wbregwrite", 32'(WbRegWrite), 32'd0);
        checkOutput("rst_wbdata", WbData, 32'd0);
        checkOutput("rst_misalign", 32'(Misalign), 32'd0);
        checkOutput("rst_buserr", 32'(BusErr), 32'd0);
      end else begin
        checkOutput("stall", 32'(Stall), 32'(expStall));
        checkOutput("memreq", 32'(mif.MemReq), 32'(expReq));
        if (expReq) begin
          checkOutput("memaddr", mif.MemAddr, expAddr);
          checkOutput("memwe", 32'(mif.MemWe), 32'(expWe));
          checkOutput("membe", 32'(mif.MemBe), 32'(expBe));
          if (expWe) checkOutput("memwdata", mif.MemWdata, expWdata);
        end
        if (evq.size() > 0) begin
          ev = evq.pop_front();
          checkOutput("wbvalid", 32'(WbValid), 32'd1);
          checkOutput("misalign", 32'(Misalign), 32'(ev.mis));
          checkOutput("buserr", 32'(BusErr), 32'(ev.berr));
          checkOutput("wbregwrite", 32'(WbRegWrite), 32'(ev.rw));
          if (ev.chkData) begin
            checkOutput("wbrd", 32'(WbRd), 32'(ev.rd));
            checkOutput("wbdata", WbData, ev.data);
          end
        end else begin
          checkOutput("wbvalid_idle", 32'(WbValid), 32'd0);
          checkOutput("wbregwrite_idle", 32'(WbRegWrite), 32'd0);
          checkOutput("misalign_idle", 32'(Misalign), 32'd0);
          checkOutput("buserr_idle", 32'(BusErr), 32'd0);
        end
      end
    end
  end

  task automatic idleCycle();
    InValid = 1'b0;
    MemRead = 1'(($urandom % 2));
    MemWrite = 1'b0;
    ALU_result = $urandom;
    mif.MemReady = 1'(($urandom % 2));
    mif.MemRvalid = 1'(($urandom % 2));
    mif.MemRdata = $urandom;
    expStall = 1'b0;
    expReq = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One instruction from IDLE back to IDLE; memory answers MemReady in REQ cycle rdyDel
  // and MemRvalid rvDel cycles into WAIT.
  task automatic applyStimulus(input logic rd_, input logic wr_, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] rs2,
                               input logic [4:0] rd, input logic rw, input int rdyDel,
                               input int rvDel, input logic [31:0] rdata);
    ev_t  ev;
    logic done, inWait, fin, tout;
    InValid = 1'b1; MemRead = rd_; MemWrite = wr_; Funct3 = f3;
    ALU_result = addr; Rs2Data = rs2; RdIn = rd; RegWriteIn = rw;
    mif.MemReady = 1'b0;
    mif.MemRvalid = 1'(($urandom % 2));
    mif.MemRdata = $urandom;
    expReq = 1'b0;
    ev = '{rw: 1'b0, rd: rd, data: 32'd0, chkData: 1'b0, mis: 1'b0, berr: 1'b0};
    if (!(rd_ || wr_) || (addr % sizeBytes(f3) != 0)) begin
      expStall = 1'b0;
      if (rd_ || wr_) ev.mis = 1'b1;
      else begin ev.rw = rw; ev.data = addr; ev.chkData = 1'b1; end
      @(posedge clk);
      evq.push_back(ev);
      #1;
      InValid = 1'b0;
      return;
    end
    expStall = 1'b1;
    @(posedge clk);
    #1;
    expWe = wr_;
    expAddr = addr & ~32'd3;
    expBe = modelBe(f3, addr);
    expWdata = modelWdata(f3, rs2);
    done = 1'b0;
    inWait = 1'b0;
    for (int i = 0; i < TO + 2 && !done; i++) begin
      if (!inWait) begin
        mif.MemReady = (i == rdyDel);
        mif.MemRvalid = 1'(($urandom % 2));
        mif.MemRdata = $urandom;
        fin = mif.MemReady && wr_;
        expReq = 1'b1;
      end else begin
        mif.MemReady = 1'b0;
        mif.MemRvalid = (i == rdyDel + 1 + rvDel);
        mif.MemRdata = mif.MemRvalid ? rdata : $urandom;
        fin = mif.MemRvalid;
        expReq = 1'b0;
      end
      tout = (i == TO - 1) && !fin && !(!inWait && mif.MemReady);
      expStall = !(fin || tout);
      if (expStall) begin
        InValid = 1'(($urandom % 2)); MemRead = 1'(($urandom % 2)); MemWrite = 1'(($urandom % 2));
        ALU_result = $urandom; Funct3 = 3'(($urandom % 8)); RdIn = 5'(($urandom % 32));
      end else begin
        InValid = 1'b0;
      end
      @(posedge clk);
      if (fin) begin
        if (!wr_) begin
          ev.rw = rw;
          ev.data = modelLoad(f3, addr, rdata);
          ev.chkData = 1'b1;
        end
        evq.push_back(ev);
        done = 1'b1;
      end else if (tout) begin
        ev.berr = 1'b1;
        evq.push_back(ev);
        done = 1'b1;
      end else if (!inWait && mif.MemReady) begin
        inWait = 1'b1;
      end
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL access_bound: got no completion, expected one within %0d cycles", TO + 2);
    end
    InValid = 1'b0;
    mif.MemRvalid = 1'b0;
    mif.MemReady = 1'b0;
    expReq = 1'b0;
    expStall = 1'b0;
  endtask

  initial begin
    logic [2:0] f3;
    int         kind, rdyDel;
    InValid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; RegWriteIn = 1'b0;
    ALU_result = '0; Rs2Data = '0; Funct3 = '0; RdIn = '0;
    mif.MemReady = 1'b0; mif.MemRvalid = 1'b0; mif.MemRdata = '0;
    #2;
    checkOutput("reset_memreq", 32'(mif.MemReq), 32'd0);
    checkOutput("reset_wbvalid", 32'(WbValid), 32'd0);
    checkOutput("reset_wbdata", WbData, 32'd0);
    checkOutput("reset_wbrd", 32'(WbRd), 32'd0);
    checkOutput("reset_misalign", 32'(Misalign), 32'd0);
    checkOutput("reset_buserr", 32'(BusErr), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOn = 1'b1;

    checkOutput("pin_lb_ext", modelLoad(3'b000, 32'h103, 32'hAB000000), 32'hFFFFFFAB);
    checkOutput("pin_lhu_ext", modelLoad(3'b101, 32'h202, 32'h8001FFFF), 32'h00008001);
    checkOutput("pin_be_lb", 32'(modelBe(3'b000, 32'h103)), 32'h8);
    checkOutput("pin_be_lhu", 32'(modelBe(3'b101, 32'h202)), 32'hC);
    checkOutput("pin_be_sb", 32'(modelBe(3'b000, 32'h301)), 32'h2);
    checkOutput("pin_wd_sb", modelWdata(3'b000, 32'h000000C5), 32'hC5C5C5C5);

    $display("[TB] directed accesses");
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h00001234, 32'd0, 5'd5, 1'b1, 0, 0, 32'd0);
    checkOutput("lit_pass_data", WbData, 32'h00001234);
    checkOutput("lit_pass_rd", 32'(WbRd), 32'd5);
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 5'd6, 1'b1, 0, 0, 32'hAB000000);
    checkOutput("lit_lb_data", WbData, 32'hFFFFFFAB);
    applyStimulus(1'b1, 1'b0, 3'b101, 32'h202, 32'd0, 5'd7, 1'b1, 4, 0, 32'h8001FFFF);
    checkOutput("lit_lhu_data", WbData, 32'h00008001);
    applyStimulus(1'b0, 1'b1, 3'b000, 32'h301, 32'h000000C5, 5'd8, 1'b0, 0, 0, 32'd0);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h304, 32'd0, 5'd9, 1'b1, 1, 1, 32'h12345678);
    checkOutput("lit_lw_data", WbData, 32'h12345678);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h402, 32'd0, 5'd10, 1'b1, 0, 0, 32'd0);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h600, 32'd0, 5'd11, 1'b1, 100, 0, 32'd0);
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h700, 32'd0, 5'd12, 1'b1, 2, 4, 32'h00000080);
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h802, 32'd0, 5'd13, 1'b1, 1, 20, 32'd0);
    idleCycle();

    $display("[TB] randomized accesses");
    for (int n = 0; n < 300; n++) begin
      kind = int'($urandom % 8);
      rdyDel = ($urandom % 12 == 0) ? 9 : int'($urandom % 5);
      if (kind == 0) idleCycle();
      else if (kind < 4)
        applyStimulus(1'b0, 1'b0, 3'(($urandom % 8)), $urandom, $urandom, 5'(($urandom % 32)),
                      1'(($urandom % 2)), 0, 0, 32'd0);
      else if (kind < 6) begin
        f3 = 3'(($urandom % 8));
        applyStimulus(1'b1, 1'b0, f3, $urandom, $urandom, 5'(($urandom % 32)),
                      1'(($urandom % 2)), rdyDel, int'($urandom % 5), $urandom);
      end else begin
        f3 = 3'(($urandom % 3));
        applyStimulus(1'b0, 1'b1, f3, $urandom, $urandom, 5'(($urandom % 32)),
                      1'(($urandom % 2)), rdyDel, 0, 32'd0);
      end
    end

    $display("[TB] reset during WAIT");
    InValid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010;
    ALU_result = 32'h500; RdIn = 5'd7; RegWriteIn = 1'b1;
    mif.MemReady = 1'b0; mif.MemRvalid = 1'b0;
    expStall = 1'b1; expReq = 1'b0;
    @(posedge clk);
    #1;
    InValid = 1'b0; mif.MemReady = 1'b1;
    expReq = 1'b1; expWe = 1'b0; expAddr = 32'h500; expBe = 4'hF;
    @(posedge clk);
    #1;
    mif.MemReady = 1'b0;
    expReq = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_memreq", 32'(mif.MemReq), 32'd0);
    checkOutput("async_rst_stall", 32'(Stall), 32'd0);
    checkOutput("async_rst_wbvalid", 32'(WbValid), 32'd0);
    checkOutput("async_rst_wbdata", WbData, 32'd0);
    expStall = 1'b0;
    evq.delete();
    mif.MemRvalid = 1'b1;
    mif.MemRdata = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mif.MemRvalid = 1'b0;
    idleCycle();
    idleCycle();

    checkOutput("events_drained", 32'(evq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
